// File: rtl/std_fp_sat_acc_if.sv
// Go/done stream bundle between a fixed-point term producer and the saturating accumulator.
// The accumulator attaches to the slave modport; the producer drives the master side.
interface std_fp_sat_acc_if #(
  parameter int WIDTH = 4
);
  logic             i_go;
  logic [WIDTH-1:0] i_in;
  logic             i_in_valid;
  logic [WIDTH-1:0] o_out;
  logic             o_done;
  logic             o_overflow;

  modport master (
    output i_go, i_in, i_in_valid,
    input  o_out, o_done, o_overflow
  );

  modport slave (
    input  i_go, i_in, i_in_valid,
    output o_out, o_done, o_overflow
  );
endinterface

// File: rtl/std_fp_sat_acc.sv
// Saturating accumulator: adds COUNT fixed-point terms in a widened register and returns the sum
// clamped to WIDTH bits, with a one-cycle done pulse and a sticky-until-next-result overflow flag.
module std_fp_sat_acc #(
  parameter int WIDTH      = 4,
  parameter int INT_WIDTH  = 2,
  parameter int FRAC_WIDTH = 2,
  parameter bit SIGNED     = 1'b1,
  parameter int COUNT      = 4
) (
  input logic                i_clk,
  input logic                i_reset,
  std_fp_sat_acc_if.slave    bus
);
  localparam int AW = WIDTH + $clog2(COUNT) + 1;
  localparam int CW = $clog2(COUNT + 1);

  localparam logic [AW-1:0] S_MAX = {{(AW-WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic [AW-1:0] S_MIN = {{(AW-WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};
  localparam logic [AW-1:0] U_MAX = {{(AW-WIDTH){1'b0}}, {WIDTH{1'b1}}};

  if (INT_WIDTH + FRAC_WIDTH != WIDTH) begin : g_bad_split
    $error("INT_WIDTH + FRAC_WIDTH must equal WIDTH");
  end

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t           r_state, w_state_nxt;
  logic [AW-1:0]    r_acc, w_acc_nxt;
  logic [CW-1:0]    r_cnt, w_cnt_nxt;
  logic [WIDTH-1:0] r_out, w_out_nxt;
  logic             r_done, w_done_nxt;
  logic             r_ovf, w_ovf_nxt;
  logic [WIDTH:0]   w_clamp;

  function automatic logic [AW-1:0] ext_f(input logic [WIDTH-1:0] v);
    if (SIGNED) begin
      ext_f = {{(AW-WIDTH){v[WIDTH-1]}}, v};
    end else begin
      ext_f = {{(AW-WIDTH){1'b0}}, v};
    end
  endfunction

  // Returns {clamped, value}; unsigned sums are never negative since terms are zero-extended.
  function automatic logic [WIDTH:0] clamp_f(input logic [AW-1:0] a);
    if (SIGNED) begin
      if ($signed(a) > $signed(S_MAX)) begin
        clamp_f = {1'b1, S_MAX[WIDTH-1:0]};
      end else if ($signed(a) < $signed(S_MIN)) begin
        clamp_f = {1'b1, S_MIN[WIDTH-1:0]};
      end else begin
        clamp_f = {1'b0, a[WIDTH-1:0]};
      end
    end else begin
      if (a > U_MAX) begin
        clamp_f = {1'b1, U_MAX[WIDTH-1:0]};
      end else begin
        clamp_f = {1'b0, a[WIDTH-1:0]};
      end
    end
  endfunction

  // Next-state and datapath update for the IDLE/ACCUM/DONE sequence.
  always_comb begin
    w_state_nxt = r_state;
    w_acc_nxt   = r_acc;
    w_cnt_nxt   = r_cnt;
    w_out_nxt   = r_out;
    w_ovf_nxt   = r_ovf;
    w_done_nxt  = 1'b0;
    w_clamp     = clamp_f(r_acc);
    case (r_state)
      S_IDLE: begin
        if (bus.i_go) begin
          w_state_nxt = S_ACCUM;
          w_acc_nxt   = '0;
          w_cnt_nxt   = '0;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_ACCUM: begin
        if (!bus.i_go) begin
          w_state_nxt = S_IDLE;
        end else if (bus.i_in_valid) begin
          w_acc_nxt = r_acc + ext_f(bus.i_in);
          w_cnt_nxt = r_cnt + CW'(1);
          if (w_cnt_nxt == CW'(COUNT)) begin
            w_state_nxt = S_DONE;
          end else begin
            w_state_nxt = S_ACCUM;
          end
        end else begin
          w_state_nxt = S_ACCUM;
        end
      end
      S_DONE: begin
        w_out_nxt   = w_clamp[WIDTH-1:0];
        w_ovf_nxt   = w_clamp[WIDTH];
        w_done_nxt  = 1'b1;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // State and result registers; reset wins over any request.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_acc   <= '0;
      r_cnt   <= '0;
      r_out   <= '0;
      r_done  <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_acc   <= w_acc_nxt;
      r_cnt   <= w_cnt_nxt;
      r_out   <= w_out_nxt;
      r_done  <= w_done_nxt;
      r_ovf   <= w_ovf_nxt;
    end
  end

  assign bus.o_out      = r_out;
  assign bus.o_done     = r_done;
  assign bus.o_overflow = r_ovf;
endmodule

// File: doc/std_fp_sat_acc.md
# std_fp_sat_acc

Sequential fixed-point saturating accumulator that sits directly downstream of the pipelined fixed-point multiplier. It consumes a stream of `COUNT` products, using the multiplier's `out` as `in` and its `done` as `in_valid`. It sums them in a widened internal register and returns the sum clamped to `WIDTH` bits, with a one-cycle `done` pulse and an `overflow` flag. It follows the go/done handshake used by the rest of the fixed-point library.

## Interface
- `WIDTH`, 4: total bits of input/output fixed-point words.
- `INT_WIDTH`, 2: integer bits. `INT_WIDTH + FRAC_WIDTH == WIDTH` is required.
- `FRAC_WIDTH`, 2: fractional bits. Binary points of `in` and `out` are identical, so no shifting is performed.
- `SIGNED`, 1: 1 = two's-complement arithmetic and clamping; 0 = unsigned.
- `COUNT`, 4: number of terms per operation, ≥1.
- `clk`  in  1  clock, rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `go`  in  1  start/hold request. Must stay high for the whole operation.
- `in`  in  WIDTH  product term.
- `in_valid`  in  1  `in` is a term to add this cycle.
- `out`  out  WIDTH  saturated sum. Holds until the next `done`.
- `done`  out  1  one-cycle pulse; `out` and `overflow` are valid.
- `overflow`  out  1  the last result was clamped. Holds with `out`.

## Operation
- Accumulator `acc` width is `AW = WIDTH + $clog2(COUNT) + 1`. The sum of `COUNT` terms can never wrap internally.
- Terms enter `acc` sign-extended when `SIGNED=1` and zero-extended when `SIGNED=0`.
- Term counter `cnt` runs from 0 to `COUNT`.
- FSM states:
  - IDLE:
    - `go` high: clear `acc` and `cnt`, go to ACCUM.
    - `in_valid` is ignored in IDLE, including in the start cycle.
  - ACCUM:
    - `go` low: abort to IDLE. `out`, `overflow` unchanged; no `done`.
    - Else if `in_valid`: `acc += ext(in)`, `cnt += 1`.
    - When the accepted term is the `COUNT`th, go to DONE.
    - Cycles with `in_valid` low are gaps: no change.
  - DONE:
    - Register `out = clamp(acc)`, `overflow = (clamp changed value)`, and pulse `done`.
    - Return to IDLE unconditionally. `in_valid` is ignored.
- Clamp rule:
  - SIGNED: limits are `[-2^(WIDTH-1), 2^(WIDTH-1)-1]` as raw integers.
  - Unsigned: limits are `[0, 2^WIDTH-1]`.
  - Otherwise the result is the low `WIDTH` bits of `acc`.
- Reset (any state, including mid-operation):
  - State IDLE.
  - `acc`, `cnt`, `out`, `done`, `overflow` all cleared to 0.
  - Reset has priority over `go`.

## Timing
- Cycle 0: `go` rises in IDLE. ACCUM starts in cycle 1, and terms are sampled from cycle 1 onward.
- Last term accepted at edge k: DONE is in cycle k+1. `done`, `out` and `overflow` are registered and visible in cycle k+2, for one cycle.
- Minimum latency from `go` to `done` is `COUNT + 2` cycles, with `in_valid` continuously high from cycle 1.
- If `go` is held high continuously, the next operation starts in the IDLE cycle right after DONE. There is no extra gap requirement.
- `done` never asserts twice without an intervening IDLE.
- `done` never asserts after an abort.

## Test plan
All scenarios use defaults (signed Q2.2, COUNT=4) unless stated.
1. Basic sum: `go` high, then 4 consecutive valid terms of 0.25 (`4'b0001`) -> `done` 6 cycles after `go`, `out=4'b0100` (1.0), `overflow=0`.
2. Mixed signs with gaps: terms 0.75, −0.5, 0.25, −0.25 (`0011`, `1110`, `0001`, `1111`), with `in_valid` low for 2 cycles between terms 2 and 3 -> `out=4'b0001`, `overflow=0`, `done` delayed by exactly 2 cycles.
3. Saturation:
   - 4×0.5 (`0010`) -> `out=4'b0111`, `overflow=1`.
   - 4×−1.0 (`1100`) -> `out=4'b1000`, `overflow=1`.
4. Abort:
   - 2 terms accepted, then `go` low for 1 cycle -> no `done`; `out` keeps its previous value.
   - New run of 4×0.25 -> `out=4'b0100`, confirming the accumulator was cleared.
5. Reset mid-operation: `reset` after 3 terms -> the next cycle shows `out=0`, `overflow=0`, `done=0`. A subsequent full run gives the correct sum.
6. Unsigned variant (`SIGNED=0`, COUNT=2):
   - `4'b1100` + `4'b0011` -> `out=4'b1111`, `overflow=0`.
   - `4'b1100` + `4'b0100` -> `out=4'b1111`, `overflow=1`.
